uart_prog_loader: RTL and testbench

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

---
 rtl/uart_prog_loader_pkg.sv | 19 +
 rtl/uart_prog_loader_byte_to_word.sv | 39 +++
 rtl/uart_prog_loader.sv | 125 ++++++++++++
 tb/tb_uart_prog_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_prog_loader_pkg.sv
// Shared constants and FSM state type for the UART program loader.
// Imported by the loader top level.
package uart_prog_loader_pkg;

    localparam logic [7:0]  SYNC_BYTE          = 8'hA5;
    localparam logic [31:0] DEF_BASE_ADDR      = 32'h0000_0000;
    localparam int unsigned DEF_MAX_WORDS      = 1024;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/uart_prog_loader_byte_to_word.sv
// Little-endian byte-to-word assembler. Four accepted bytes form one word.
// The first byte lands in bits [7:0]. Each completed word produces a one-cycle write strobe.
module byte_to_word (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        last_byte,
    output logic [31:0] word_out,
    output logic        word_we
);

    logic [1:0]  byte_cnt;
    logic [23:0] shift;

    assign last_byte = byte_valid && (byte_cnt == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
            shift    <= '0;
            word_out <= '0;
            word_we  <= 1'b0;
        end else begin
            word_we <= last_byte;
            if (clr) begin
                byte_cnt <= '0;
            end else if (byte_valid) begin
                // The output word is a separate register, so it stays stable while the next word assembles.
                if (last_byte)
                    word_out <= {byte_in, shift};
                shift    <= {byte_in, shift[23:8]};
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a program into instruction memory from a UART byte stream.
// Frame format: sync, 16-bit word count, little-endian words, then an XOR checksum.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = DEF_BASE_ADDR,
    parameter int unsigned MAX_WORDS      = DEF_MAX_WORDS,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    state_t      state, state_n;
    logic [7:0]  len_lo, csum;
    logic [15:0] len, len_rx, word_index;
    logic [31:0] tmo_cnt;
    logic        err_set, err_clr, tmo_hit, last_byte;

    assign len_rx    = {rx_data, len_lo};
    assign cpu_hold  = (state != ST_IDLE);
    assign load_done = (state == ST_DONE);
    assign tmo_hit   = (state != ST_IDLE) && (state != ST_DONE) && !rx_valid
                       && (tmo_cnt == TIMEOUT_CYCLES - 1);

    byte_to_word u_b2w (
        .clk        (clk),
        .rst        (rst),
        .clr        (state != ST_DATA),
        .byte_in    (rx_data),
        .byte_valid (rx_valid && (state == ST_DATA)),
        .last_byte  (last_byte),
        .word_out   (imem_wdata),
        .word_we    (imem_we)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        err_set = 1'b0;
        err_clr = 1'b0;
        case (state)
            ST_IDLE: if (rx_valid && rx_data == SYNC_BYTE) begin
                state_n = ST_LEN_LO;
                err_clr = 1'b1;
            end
            ST_LEN_LO: if (rx_valid) state_n = ST_LEN_HI;
            ST_LEN_HI: if (rx_valid) begin
                if (len_rx == 16'd0 || {16'd0, len_rx} > MAX_WORDS) begin
                    state_n = ST_IDLE;
                    err_set = 1'b1;
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_DATA: if (last_byte && (word_index + 16'd1 == len)) state_n = ST_CSUM;
            ST_CSUM: if (rx_valid) begin
                if (rx_data == csum) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_IDLE;
                    err_set = 1'b1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        if (tmo_hit) begin
            state_n = ST_IDLE;
            err_set = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_lo     <= '0;
            len        <= '0;
            csum       <= '0;
            word_index <= '0;
            tmo_cnt    <= '0;
            imem_addr  <= BASE_ADDR;
            load_err   <= 1'b0;
        end else begin
            tmo_cnt <= (rx_valid || state == ST_IDLE) ? '0 : tmo_cnt + 32'd1;
            if (err_clr)      load_err <= 1'b0;
            else if (err_set) load_err <= 1'b1;
            case (state)
                ST_IDLE: if (rx_valid && rx_data == SYNC_BYTE) begin
                    csum       <= '0;
                    word_index <= '0;
                end
                ST_LEN_LO: if (rx_valid) begin
                    len_lo <= rx_data;
                    csum   <= csum ^ rx_data;
                end
                ST_LEN_HI: if (rx_valid) begin
                    len  <= len_rx;
                    csum <= csum ^ rx_data;
                end
                ST_DATA: if (rx_valid) begin
                    csum <= csum ^ rx_data;
                    // Address is registered alongside the assembled word so both change together with imem_we.
                    if (last_byte) begin
                        imem_addr  <= BASE_ADDR + {14'd0, word_index, 2'b00};
                        word_index <= word_index + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: randomized and directed frames.
// Each frame is checked against a frame-level reference model.
module tb_uart_prog_loader;

    localparam logic [7:0]  SYNC = 8'hA5;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 1024;
    localparam int          TMO  = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        imem_we, cpu_hold, load_done, load_err;
    logic [31:0] imem_addr, imem_wdata;

    int          total = 0;
    int          bad = 0;
    int          done_seen = 0;
    int          done_exp = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_w;
    logic [31:0] wbuf[0:3];

    always #5 clk = ~clk;

    uart_prog_loader #(
        .BASE_ADDR      (BASE),
        .MAX_WORDS      (MAXW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && imem_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %08h@%08h expected none", imem_wdata, imem_addr);
            end else begin
                exp_w = exp_q.pop_front();
                chk("write_addr", {32'd0, imem_addr}, {32'd0, exp_w[63:32]});
                chk("write_data", {32'd0, imem_wdata}, {32'd0, exp_w[31:0]});
            end
        end
        if (rst && load_done) done_seen++;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_reset_vals();
        chk("rst_we",    {63'd0, imem_we},   64'd0);
        chk("rst_addr",  {32'd0, imem_addr}, {32'd0, BASE});
        chk("rst_wdata", {32'd0, imem_wdata}, 64'd0);
        chk("rst_hold",  {63'd0, cpu_hold},  64'd0);
        chk("rst_done",  {63'd0, load_done}, 64'd0);
        chk("rst_err",   {63'd0, load_err},  64'd0);
    endtask

    // mode: 0 correct checksum, 1 randomly corrupted checksum, 2 checksum byte forced to 0x00
    task automatic run_frame(input int len, input int mode, input int gap_max,
                             input int noise_n, input bit use_wbuf);
        logic [15:0] l16;
        logic [7:0]  cs, b;
        logic [31:0] w;
        bit          good;
        l16 = 16'(len);
        for (int n = 0; n < noise_n; n++) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h00;
            send_byte(b, int'($urandom_range(0, 2)));
        end
        send_byte(SYNC, 0);
        chk("hold_after_sync", {63'd0, cpu_hold}, 64'd1);
        cs = l16[7:0] ^ l16[15:8];
        send_byte(l16[7:0], 0);
        send_byte(l16[15:8], 0);
        if (len == 0 || len > MAXW) begin
            repeat (3) @(negedge clk);
            chk("len_err",       {63'd0, load_err}, 64'd1);
            chk("len_hold",      {63'd0, cpu_hold}, 64'd0);
            chk("len_no_writes", 64'(exp_q.size()), 64'd0);
            return;
        end
        for (int i = 0; i < len; i++) begin
            w = use_wbuf ? wbuf[i] : $urandom;
            exp_q.push_back({BASE + 32'(4 * i), w});
            for (int k = 0; k < 4; k++) begin
                b  = w[8*k +: 8];
                cs = cs ^ b;
                send_byte(b, (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
            end
        end
        if (mode == 0)      b = cs;
        else if (mode == 1) b = cs ^ 8'($urandom_range(1, 255));
        else                b = 8'h00;
        good = (b == cs);
        if (good) done_exp++;
        send_byte(b, 0);
        repeat (3) @(negedge clk);
        chk("frame_err",      {63'd0, load_err}, {63'd0, !good});
        chk("frame_hold",     {63'd0, cpu_hold}, 64'd0);
        chk("done_count",     64'(done_seen), 64'(done_exp));
        chk("writes_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b1;
        @(negedge clk);

        // Directed good frame, then the same payload with checksum 0x00
        wbuf[0] = 32'h0000_0013;
        wbuf[1] = 32'h0010_0093;
        run_frame(2, 0, 0, 0, 1'b1);
        run_frame(2, 2, 0, 0, 1'b1);

        // Illegal lengths: zero and one past the maximum
        run_frame(0, 0, 0, 0, 1'b0);
        run_frame(MAXW + 1, 0, 0, 0, 1'b0);

        // Noise before sync is ignored
        send_byte(8'h00, 1);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 2);
        run_frame(2, 0, 1, 0, 1'b1);

        // Timeout after a partial word
        send_byte(SYNC, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        repeat (TMO - 5) @(negedge clk);
        chk("tmo_hold_before", {63'd0, cpu_hold}, 64'd1);
        chk("tmo_err_before",  {63'd0, load_err}, 64'd0);
        repeat (10) @(negedge clk);
        chk("tmo_err",      {63'd0, load_err}, 64'd1);
        chk("tmo_hold",     {63'd0, cpu_hold}, 64'd0);
        chk("tmo_no_write", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a frame, then a clean reload from BASE
        send_byte(SYNC, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals();
        rst = 1'b1;
        @(negedge clk);
        wbuf[0] = 32'hDEAD_BEEF;
        wbuf[1] = 32'h0123_4567;
        wbuf[2] = 32'hA5A5_005A;
        run_frame(3, 0, 2, 0, 1'b1);

        // Maximum length with a strobe on every cycle
        run_frame(MAXW, 0, 0, 0, 1'b0);

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            run_frame(int'($urandom_range(1, 12)),
                      ($urandom_range(0, 3) == 0) ? 1 : 0,
                      int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)),
                      1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
